// File: rtl/iob_mux_arb_pkg.sv
// iob_mux_arb shared definitions: parameter defaults and lock FSM states.
// Feature macro IOB_MUX_ARB_LAST_LOCK_EN selects frame locking on last.
package iob_mux_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int N_DEF      = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_st_e;

endpackage

// File: rtl/iob_rr_grant.sv
// Round-robin grant: rotate requests so ptr is at bit 0,
// then pick the lowest set bit and map it back to a stream index.
module iob_rr_grant
    import iob_mux_arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] gnt_id_o,
    output logic             gnt_vld_o
);

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    int             idx;

    // rotate-then-priority-encode; the reverse loop lets the lowest bit win
    always_comb begin
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        req2      = {req_i, req_i};
        rot       = N'(req2 >> ptr_i);
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx       = (int'(ptr_i) + i) % N;
                gnt_id_o  = SEL_W'(idx);
                gnt_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_mux_arb.sv
// N-to-1 valid/ready stream merge with round-robin arbitration and a
// registered output. Define IOB_MUX_ARB_LAST_LOCK_EN to keep frames whole.
module iob_mux_arb
    import iob_mux_arb_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  N      = N_DEF,
    localparam int SEL_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [N*DATA_W-1:0] data_i,
    input  logic [N-1:0]      valid_i,
    input  logic [N-1:0]      last_i,
    output logic [N-1:0]      ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              last_o,
    output logic [SEL_W-1:0]  sel_o,
    input  logic              ready_i
);

    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    logic [SEL_W-1:0]  arb_id;
    logic              arb_vld;
    logic [SEL_W-1:0]  gnt_id;
    logic              gnt_vld;
    logic              can_load;
    logic              xfer;
    logic              ptr_adv;

    iob_rr_grant #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_grant (
        .req_i     (valid_i),
        .ptr_i     (ptr_q),
        .gnt_id_o  (arb_id),
        .gnt_vld_o (arb_vld)
    );

`ifdef IOB_MUX_ARB_LAST_LOCK_EN
    lock_st_e         st_q, st_d;
    logic [SEL_W-1:0] lock_id_q, lock_id_d;
    logic             gnt_last;

    // lock state and owner of the frame in progress
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            st_q      <= ST_IDLE;
            lock_id_q <= '0;
        end else begin
            st_q      <= st_d;
            lock_id_q <= lock_id_d;
        end
    end

    // while locked only the owner may be served; a gap in it is a bubble
    always_comb begin
        gnt_id  = arb_id;
        gnt_vld = arb_vld;
        if (st_q == ST_LOCKED) begin
            gnt_id  = lock_id_q;
            gnt_vld = valid_i[lock_id_q];
        end
    end

    assign gnt_last = last_i[gnt_id];
    assign ptr_adv  = xfer && gnt_last;

    // open a lock on a non-final beat, close it on the owner's last beat
    always_comb begin
        st_d      = st_q;
        lock_id_d = lock_id_q;
        unique case (st_q)
            ST_IDLE: begin
                if (xfer && !gnt_last) begin
                    st_d      = ST_LOCKED;
                    lock_id_d = gnt_id;
                end
            end
            ST_LOCKED: begin
                if (xfer && gnt_last) begin
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end
`else
    assign gnt_id  = arb_id;
    assign gnt_vld = arb_vld;
    assign ptr_adv = xfer;
`endif

    assign can_load = !valid_q || ready_i;
    assign xfer     = rst_n_i && can_load && gnt_vld;

    // one-hot accept towards the granted producer
    always_comb begin
        ready_o = '0;
        if (xfer) begin
            ready_o[gnt_id] = 1'b1;
        end
    end

    // output stage: load on transfer, retire on downstream accept
    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (xfer) begin
            data_d  = data_i[int'(gnt_id)*DATA_W +: DATA_W];
            last_d  = last_i[gnt_id];
            sel_d   = gnt_id;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // pointer moves past the stream whose grant is released
    always_comb begin
        ptr_d = ptr_q;
        if (ptr_adv) begin
            if (gnt_id == SEL_W'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + 1'b1;
            end
        end
    end

    // output and pointer registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign data_o  = data_q;
    assign last_o  = last_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_iob_mux_arb.sv
// Scoreboard bench for iob_mux_arb (N=4, DATA_W=8): a cycle model
// predicts accepts and beats; a monitor checks beats as they leave.
module tb_iob_mux_arb;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]  valid_i;
    logic [N-1:0]  last_i;
    logic [N-1:0]  ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic [SW-1:0] sel_o;
    logic          ready_i;

    always #5 clk = ~clk;

    iob_mux_arb #(
        .DATA_W (DW),
        .N      (N)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .sel_o   (sel_o),
        .ready_i (ready_i)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [SW-1:0] s;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model state
    int m_ptr  = 0;
    bit m_val  = 0;
    bit m_zero = 1;
    bit m_lock = 0;
    int m_lid  = 0;

    task automatic model_step();
        int            g;
        int            c;
        bit            gv;
        bit            cl;
        logic [N-1:0]  er;
        beat_t         b;
        g  = 0;
        gv = 0;
        if (m_lock) begin
            g  = m_lid;
            gv = valid_i[m_lid];
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!gv && valid_i[c]) begin
                    g  = c;
                    gv = 1;
                end
            end
        end
        cl = !m_val || ready_i;
        er = '0;
        if (rst_n_i && cl && gv) er[g] = 1'b1;
        check("ready_o", 32'(ready_o), 32'(er));
        check("valid_o", 32'(valid_o), 32'(m_val));
        if (m_zero) begin
            check("rst_sel_o", 32'(sel_o), 32'd0);
            check("rst_data_o", 32'(data_o), 32'd0);
            check("rst_last_o", 32'(last_o), 32'd0);
        end
        if (!rst_n_i) begin
            m_val  = 0;
            m_ptr  = 0;
            m_lock = 0;
            m_zero = 1;
            exp_q.delete();
        end else if (er != '0) begin
            b.d = data_i[g*DW +: DW];
            b.l = last_i[g];
            b.s = SW'(g);
            exp_q.push_back(b);
            m_val  = 1;
            m_zero = 0;
`ifdef IOB_MUX_ARB_LAST_LOCK_EN
            if (last_i[g]) begin
                m_lock = 0;
                m_ptr  = (g + 1) % N;
            end else begin
                m_lock = 1;
                m_lid  = g;
            end
`else
            m_ptr = (g + 1) % N;
`endif
        end else if (m_val && ready_i) begin
            m_val = 0;
        end
    endtask

    // model: runs just after the monitor so popped beats precede flushes
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            model_step();
        end
    end

    // monitor: compare every beat the DUT hands downstream
    initial begin
        beat_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat: got data %0h sel %0d, want no beat",
                             data_o, sel_o);
                end else begin
                    e = exp_q.pop_front();
                    check("data_o", 32'(data_o), 32'(e.d));
                    check("sel_o", 32'(sel_o), 32'(e.s));
                    check("last_o", 32'(last_o), 32'(e.l));
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic [N-1:0] v,
                       input logic [N-1:0] l, input logic [N*DW-1:0] d,
                       input logic rdy);
        rst_n_i = r;
        valid_i = v;
        last_i  = l;
        data_i  = d;
        ready_i = rdy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*DW-1:0] pk(input logic [7:0] d0,
                                          input logic [7:0] d1,
                                          input logic [7:0] d2,
                                          input logic [7:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    initial begin
        // reset held with every stream requesting
        cyc(1'b0, 4'hF, 4'hF, 32'(-1), 1'b1);
        cyc(1'b0, 4'hF, 4'hF, 32'(-1), 1'b1);
        cyc(1'b0, 4'hF, 4'hF, 32'(-1), 1'b1);

        // fairness: single-beat frames from everybody
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 4'hF, 4'hF, $urandom, 1'b1);
        cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b1);

        // backpressure on a beat from stream 2
        cyc(1'b1, 4'b0100, 4'hF, pk(8'h00, 8'h00, 8'hA5, 8'h00), 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 4'hF, 4'hF, $urandom, 1'b0);
        cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b1);
        cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b1);

        // stream 1 frame with a mid-frame gap, stream 3 always pending
        cyc(1'b1, 4'b1010, 4'b1000, pk(8'h0, 8'h11, 8'h0, 8'h33), 1'b1);
        cyc(1'b1, 4'b1010, 4'b1000, pk(8'h0, 8'h12, 8'h0, 8'h34), 1'b1);
        cyc(1'b1, 4'b1000, 4'b1000, pk(8'h0, 8'h00, 8'h0, 8'h35), 1'b1);
        cyc(1'b1, 4'b1010, 4'b1010, pk(8'h0, 8'h13, 8'h0, 8'h36), 1'b1);
        cyc(1'b1, 4'b1000, 4'b1000, pk(8'h0, 8'h00, 8'h0, 8'h37), 1'b1);
        cyc(1'b1, 4'b1000, 4'b1000, pk(8'h0, 8'h00, 8'h0, 8'h38), 1'b1);
        cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b1);

        // reset in the middle of a stream-1 frame
        cyc(1'b1, 4'b0010, 4'b0000, pk(8'h0, 8'h11, 8'h0, 8'h0), 1'b1);
        cyc(1'b1, 4'b0010, 4'b0000, pk(8'h0, 8'h12, 8'h0, 8'h0), 1'b1);
        cyc(1'b0, 4'b1010, 4'b0000, pk(8'h0, 8'h13, 8'h0, 8'h3C), 1'b1);
        cyc(1'b1, 4'b1000, 4'b1000, pk(8'h0, 8'h00, 8'h0, 8'h3D), 1'b1);
        cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b1);

        // randomized traffic with backpressure and rare resets
        for (int i = 0; i < 1500; i++)
            cyc(($urandom % 100) != 0, 4'($urandom), 4'($urandom),
                $urandom, ($urandom % 4) != 0);

        // drain and make sure nothing predicted was lost
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 4'h0, 4'h0, 32'h0, 1'b1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
